// File: rtl/scoot_world_controller.sv
// scoot_world_controller: toroidal food grid plus a stepping bot controller.
// A run repeats SENSE -> SETTLE x SETTLE_CYCLES -> MOVE until NUM_STEPS
// moves are done. The bot reads the l* sensors and answers on the m* inputs.
// The grid keeps eaten cells cleared across runs until reset or a load.
//
// state_dbg encoding: 0 IDLE, 1 SENSE, 2 SETTLE, 3 MOVE, 4 DONE.
//
// Handshake: there is no valid/ready pair. start and load_en are level
// samples that take effect only on an edge where the FSM is in IDLE or DONE.
// m* are sampled only on the edge that ends MOVE. The bot must have its
// request stable by then. The l* sensors are valid and held from the first
// SETTLE cycle through MOVE.
module scoot_world_controller #(
  parameter int WIDTH         = 10,
  parameter int HEIGHT        = 10,
  parameter int NUM_STEPS     = 100,
  parameter int SETTLE_CYCLES = 8,
  parameter logic [HEIGHT-1:0] INIT_COL = 10'b0010101001,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_en,
  input  logic [XW-1:0]     load_col,
  input  logic [HEIGHT-1:0] load_data,
  input  logic              mUp,
  input  logic              mRight,
  input  logic              mDown,
  input  logic              mLeft,
  output logic              lUp,
  output logic              lRight,
  output logic              lDown,
  output logic              lLeft,
  output logic [XW-1:0]     pos_x,
  output logic [YW-1:0]     pos_y,
  output logic [7:0]        score,
  output logic [15:0]       step_count,
  output logic              busy,
  output logic              done,
  output logic              pickup,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SENSE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_MOVE   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [XW-1:0] X_MAX   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_MID   = XW'(WIDTH / 2);
  localparam logic [YW-1:0] Y_MID   = YW'(HEIGHT / 2);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [XW:0]   X_LIMIT = (XW + 1)'(WIDTH);
  localparam logic [15:0]   N_STEPS = 16'(NUM_STEPS);
  localparam logic [CW-1:0] S_LAST  = CW'(SETTLE_CYCLES - 1);

  logic [2:0]        state;
  logic [CW-1:0]     settle_cnt;
  logic [HEIGHT-1:0] grid [WIDTH];

  logic              idle_or_done;
  logic              run_start;
  logic              load_ok;
  logic              cur_food;
  logic [XW-1:0]     x_inc;
  logic [XW-1:0]     x_dec;
  logic [YW-1:0]     y_inc;
  logic [YW-1:0]     y_dec;
  logic [XW-1:0]     next_x;
  logic [YW-1:0]     next_y;
  logic [15:0]       step_next;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign run_start    = start && idle_or_done;
  assign load_ok      = load_en && idle_or_done && ({1'b0, load_col} < X_LIMIT);
  assign cur_food     = grid[pos_x][pos_y];
  assign step_next    = step_count + 16'd1;

  assign busy      = (state == S_SENSE) || (state == S_SETTLE) || (state == S_MOVE);
  assign done      = (state == S_DONE);
  assign pickup    = (state == S_SENSE) && cur_food;
  assign state_dbg = state;

  // Neighbour coordinates on the torus, with explicit wrap at both edges.
  always_comb begin
    x_inc = (pos_x == X_MAX) ? '0 : pos_x + X_ONE;
    x_dec = (pos_x == '0) ? X_MAX : pos_x - X_ONE;
    y_inc = (pos_y == Y_MAX) ? '0 : pos_y + Y_ONE;
    y_dec = (pos_y == '0) ? Y_MAX : pos_y - Y_ONE;
  end

  // Requested move. Opposing requests on one axis cancel.
  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    if (mRight && !mLeft) begin
      next_x = x_inc;
    end else if (mLeft && !mRight) begin
      next_x = x_dec;
    end
    if (mUp && !mDown) begin
      next_y = y_inc;
    end else if (mDown && !mUp) begin
      next_y = y_dec;
    end
  end

  // Grid storage: column loads while idle, and food is eaten during SENSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        grid[i] <= INIT_COL;
      end
    end else if (load_ok) begin
      grid[load_col] <= load_data;
    end else if ((state == S_SENSE) && cur_food) begin
      grid[pos_x][pos_y] <= 1'b0;
    end
  end

  // Run sequencing: state, settle timer, position, score and step count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      pos_x      <= X_MID;
      pos_y      <= Y_MID;
      score      <= 8'd0;
      step_count <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (run_start) begin
            state      <= S_SENSE;
            pos_x      <= X_MID;
            pos_y      <= Y_MID;
            score      <= 8'd0;
            step_count <= 16'd0;
          end
        end
        S_SENSE: begin
          if (cur_food && (score != 8'hFF)) begin
            score <= score + 8'd1;
          end
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == S_LAST) begin
            state <= S_MOVE;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        S_MOVE: begin
          pos_x      <= next_x;
          pos_y      <= next_y;
          step_count <= step_next;
          state      <= (step_next == N_STEPS) ? S_DONE : S_SENSE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Food sensors: captured once in SENSE, held until the next SENSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lUp    <= 1'b0;
      lRight <= 1'b0;
      lDown  <= 1'b0;
      lLeft  <= 1'b0;
    end else if (state == S_SENSE) begin
      lUp    <= grid[pos_x][y_inc];
      lDown  <= grid[pos_x][y_dec];
      lRight <= grid[x_inc][pos_y];
      lLeft  <= grid[x_dec][pos_y];
    end
  end

endmodule

// File: tb/tb_scoot_world_controller.sv
// Bench for scoot_world_controller: directed move tables, multi-cycle corner
// sequences (reset mid-run, load/start interplay), then randomized runs
// checked against a grid-level reference model.
module tb_scoot_world_controller;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int NS = 8;
  localparam int SC = 8;
  localparam logic [H-1:0] INIT = 10'b0010101001;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         load_en;
  logic [3:0]   load_col;
  logic [H-1:0] load_data;
  logic         mUp, mRight, mDown, mLeft;
  logic         lUp, lRight, lDown, lLeft;
  logic [3:0]   pos_x;
  logic [3:0]   pos_y;
  logic [7:0]   score;
  logic [15:0]  step_count;
  logic         busy, done, pickup;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: the world as a plain bit array plus bot bookkeeping.
  bit mg [W][H];
  int mx, my, msc, mst;

  typedef struct {
    logic u, r, d, l;
    int   ex, ey;
  } vec_t;
  vec_t tbl [16];

  scoot_world_controller #(
    .WIDTH(W), .HEIGHT(H), .NUM_STEPS(NS), .SETTLE_CYCLES(SC), .INIT_COL(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en),
    .load_col(load_col), .load_data(load_data),
    .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
    .lUp(lUp), .lRight(lRight), .lDown(lDown), .lLeft(lLeft),
    .pos_x(pos_x), .pos_y(pos_y), .score(score), .step_count(step_count),
    .busy(busy), .done(done), .pickup(pickup), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    logic [H-1:0] iv;
    iv = INIT;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        mg[x][y] = iv[y];
    mx = W / 2; my = H / 2; msc = 0; mst = 0;
  endtask

  task automatic model_load(input int col, input logic [H-1:0] data);
    if (col < W)
      for (int y = 0; y < H; y++)
        mg[col][y] = data[y];
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, state_dbg, 0);
    check({tag, "_pos_x"}, pos_x, W / 2);
    check({tag, "_pos_y"}, pos_y, H / 2);
    check({tag, "_score"}, score, 0);
    check({tag, "_steps"}, step_count, 0);
    check({tag, "_sensors"}, {lUp, lRight, lDown, lLeft}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pickup"}, pickup, 0);
  endtask

  // Issue start (optionally with a load on the same edge); returns in SENSE.
  task automatic start_run(input logic with_load, input logic [3:0] col, input logic [H-1:0] data);
    start = 1'b1;
    load_en = with_load; load_col = col; load_data = data;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    if (with_load) model_load(col, data);
    mx = W / 2; my = H / 2; msc = 0; mst = 0;
  endtask

  task automatic load_only(input logic [3:0] col, input logic [H-1:0] data);
    load_en = 1'b1; load_col = col; load_data = data;
    @(negedge clk);
    load_en = 1'b0;
    model_load(col, data);
  endtask

  // One full step starting at the SENSE negedge; ends one negedge after MOVE.
  task automatic do_step(input logic u, input logic r, input logic d, input logic l,
                         input logic noise, output logic got_pick, output logic [3:0] got_sens);
    logic       exp_p;
    logic [3:0] exp_s;
    check("sense_state", state_dbg, 1);
    check("sense_busy", busy, 1);
    check("sense_pos_x", pos_x, mx);
    check("sense_pos_y", pos_y, my);
    check("sense_score", score, msc);
    check("sense_steps", step_count, mst);
    exp_p = mg[mx][my];
    exp_s = {mg[mx][(my + 1) % H], mg[(mx + 1) % W][my],
             mg[mx][(my - 1 + H) % H], mg[(mx - 1 + W) % W][my]};
    check("pickup", pickup, exp_p);
    got_pick = pickup;
    got_sens = 4'b0;
    if (exp_p) begin
      mg[mx][my] = 1'b0;
      if (msc < 255) msc++;
    end
    mUp = u; mRight = r; mDown = d; mLeft = l;
    for (int i = 0; i < SC; i++) begin
      if (noise) begin
        load_en   = 1'($urandom_range(0, 1));
        load_col  = 4'($urandom_range(0, 15));
        load_data = 10'($urandom);
        start     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (i == 0) begin
        check("pickup_one_cycle", pickup, 0);
        check("settle_score", score, msc);
        got_sens = {lUp, lRight, lDown, lLeft};
      end
      check("settle_state", state_dbg, 2);
      check("settle_sensors", {lUp, lRight, lDown, lLeft}, exp_s);
    end
    load_en = 1'b0; start = 1'b0;
    @(negedge clk);
    check("move_state", state_dbg, 3);
    check("move_pos_x", pos_x, mx);
    mx = (mx + int'(r) - int'(l) + W) % W;
    my = (my + int'(u) - int'(d) + H) % H;
    mst++;
    @(negedge clk);
    mUp = 0; mRight = 0; mDown = 0; mLeft = 0;
    check("step_pos_x", pos_x, mx);
    check("step_pos_y", pos_y, my);
    check("step_count", step_count, mst);
    if (mst == NS) begin
      check("end_done", done, 1);
      check("end_busy", busy, 0);
    end else begin
      check("next_state", state_dbg, 1);
    end
  endtask

  task automatic random_steps(input int n);
    logic       gp;
    logic [3:0] gs;
    logic [3:0] m;
    for (int s = 0; s < n; s++) begin
      m = 4'($urandom_range(0, 15));
      do_step(m[3], m[2], m[1], m[0], 1'b1, gp, gs);
    end
  endtask

  initial begin
    logic       gp;
    logic [3:0] gs;
    // Run A: wrap in x both ways, then a full conflict step, then up.
    tbl[0]  = '{0,1,0,0, 6,5};  tbl[1]  = '{0,1,0,0, 7,5};
    tbl[2]  = '{0,1,0,0, 8,5};  tbl[3]  = '{0,1,0,0, 9,5};
    tbl[4]  = '{0,1,0,0, 0,5};  tbl[5]  = '{0,0,0,1, 9,5};
    tbl[6]  = '{1,1,1,1, 9,5};  tbl[7]  = '{1,0,0,0, 9,6};
    // Run B: down through the y wrap, vertical conflict, then left.
    tbl[8]  = '{0,0,1,0, 5,4};  tbl[9]  = '{0,0,1,0, 5,3};
    tbl[10] = '{0,0,1,0, 5,2};  tbl[11] = '{0,0,1,0, 5,1};
    tbl[12] = '{0,0,1,0, 5,0};  tbl[13] = '{0,0,1,0, 5,9};
    tbl[14] = '{1,0,1,0, 5,9};  tbl[15] = '{0,0,0,1, 4,9};

    rst_n = 1'b0; start = 1'b0; load_en = 1'b0; load_col = '0; load_data = '0;
    mUp = 0; mRight = 0; mDown = 0; mLeft = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Run A
    start_run(1'b0, 4'd0, '0);
    for (int i = 0; i < 8; i++) begin
      do_step(tbl[i].u, tbl[i].r, tbl[i].d, tbl[i].l, 1'b0, gp, gs);
      if (i == 0) begin
        check("first_pickup", gp, 1);
        check("first_sensors", gs, 4'b0101);
        check("first_score", score, 1);
      end
      check("tbl_a_x", pos_x, tbl[i].ex);
      check("tbl_a_y", pos_y, tbl[i].ey);
    end
    repeat (5) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_pos_x", pos_x, 9);
    check("hold_pos_y", pos_y, 6);
    check("hold_steps", step_count, NS);
    check("hold_score", score, msc);

    // Run B: restart keeps eaten food; loads/starts during the run are ignored.
    start_run(1'b0, 4'd0, '0);
    check("rerun_score", score, 0);
    check("rerun_no_pickup", pickup, 0);
    for (int i = 8; i < 16; i++) begin
      do_step(tbl[i].u, tbl[i].r, tbl[i].d, tbl[i].l, 1'b1, gp, gs);
      check("tbl_b_x", pos_x, tbl[i].ex);
      check("tbl_b_y", pos_y, tbl[i].ey);
    end

    // Idle load clears column 5.
    load_only(4'd5, '0);
    start_run(1'b0, 4'd0, '0);
    do_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, gp, gs);
    check("load0_no_pickup", gp, 0);
    check("load0_up", gs[3], 0);
    check("load0_down", gs[1], 0);
    random_steps(NS - 1);

    // Load and start on the same edge: first SENSE sees the new column.
    start_run(1'b1, 4'd5, 10'h3FF);
    do_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, gp, gs);
    check("ldstart_pickup", gp, 1);
    check("ldstart_up", gs[3], 1);
    check("ldstart_down", gs[1], 1);
    random_steps(NS - 1);

    // Reset in the SETTLE phase of step 3 abandons the run and restores the grid.
    start_run(1'b0, 4'd0, '0);
    random_steps(2);
    mRight = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    model_reset();
    mRight = 1'b0;
    @(negedge clk);
    check_reset("held_reset");
    rst_n = 1'b1;
    @(negedge clk);
    start_run(1'b0, 4'd0, '0);
    do_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, gp, gs);
    check("post_reset_pickup", gp, 1);
    random_steps(NS - 1);

    // Randomized runs with random column loads (some out of range).
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 2)) load_only(4'($urandom_range(0, 15)), 10'($urandom));
      start_run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 10'($urandom));
      random_steps(NS);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
